// File: rtl/input_debounce_if.sv
// Bundles the debouncer's sample-side inputs and filtered outputs.
// The master drives ce/in_sync; the slave (the debouncer) drives the filtered results.
interface input_debounce_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             ce;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (
        output ce,
        output in_sync,
        input  level,
        input  rise,
        input  fall,
        input  changed
    );

    modport slave (
        input  ce,
        input  in_sync,
        output level,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/input_debounce.sv
// Multi-channel debouncer: each channel commits a new level only after STABLE_CYCLES
// consecutive ce ticks of disagreement, and emits one-cycle rise/fall/changed pulses.
module input_debounce #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      CNT_BITS      = 16,
    parameter int unsigned      STABLE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] INIT          = '0
) (
    input logic              clk,
    input logic              reset,
    input_debounce_if.slave  bus
);

    // A threshold of zero behaves as one: commit on the first qualifying tick.
    localparam int unsigned       Threshold = (STABLE_CYCLES == 0) ? 1 : STABLE_CYCLES;
    localparam logic [CNT_BITS-1:0] LastCnt = CNT_BITS'(Threshold - 1);

    logic [CNT_BITS-1:0] cnt_q [WIDTH];
    logic [CNT_BITS-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0]    level_q, level_d;
    logic [WIDTH-1:0]    rise_q, rise_d;
    logic [WIDTH-1:0]    fall_q, fall_d;
    logic                changed_q, changed_d;

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            // Agreement breaks the run on every clock, even without a ce tick.
            if (bus.in_sync[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (bus.ce) begin
                if (cnt_q[i] == LastCnt) begin
                    level_d[i] = bus.in_sync[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = bus.in_sync[i];
                    fall_d[i]  = ~bus.in_sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '{default: '0};
            level_q   <= INIT;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign bus.level   = level_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: dut_a uses STABLE_CYCLES=4, dut_b uses 3 for ce gating.
module tb_input_debounce;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    input_debounce_if #(.WIDTH(8)) bus_a ();
    input_debounce_if #(.WIDTH(8)) bus_b ();

    input_debounce #(
        .WIDTH(8), .CNT_BITS(16), .STABLE_CYCLES(4), .INIT(8'h00)
    ) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    input_debounce #(
        .WIDTH(8), .CNT_BITS(16), .STABLE_CYCLES(3), .INIT(8'h00)
    ) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    function automatic logic [24:0] obs_a();
        return {bus_a.level, bus_a.rise, bus_a.fall, bus_a.changed};
    endfunction

    function automatic logic [24:0] obs_b();
        return {bus_b.level, bus_b.rise, bus_b.fall, bus_b.changed};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus_a.in_sync = 8'h00;
        bus_a.ce      = 1'b1;
        bus_b.in_sync = 8'h00;
        bus_b.ce      = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] exp;
        reset         = 1'b1;
        bus_a.in_sync = 8'hFF;
        bus_a.ce      = 1'b1;
        step();
        step();
        checks++;
        if (obs_a() !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got %h required %h", obs_a(), {8'h00, 8'h00, 8'h00, 1'b0});
        end
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e < 4)       exp = {8'h00, 8'h00, 8'h00, 1'b0};
            else if (e == 4) exp = {8'hFF, 8'hFF, 8'h00, 1'b1};
            else             exp = {8'hFF, 8'h00, 8'h00, 1'b0};
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL reset_release edge %0d: got %h required %h", e, obs_a(), exp);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [24:0] exp;
        do_reset();
        bus_a.in_sync = 8'h01;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e < 4)       exp = {8'h00, 8'h00, 8'h00, 1'b0};
            else if (e == 4) exp = {8'h01, 8'h01, 8'h00, 1'b1};
            else             exp = {8'h01, 8'h00, 8'h00, 1'b0};
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL press edge %0d: got %h required %h", e, obs_a(), exp);
            end
        end
        bus_a.in_sync = 8'h00;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e < 4)       exp = {8'h01, 8'h00, 8'h00, 1'b0};
            else if (e == 4) exp = {8'h00, 8'h00, 8'h01, 1'b1};
            else             exp = {8'h00, 8'h00, 8'h00, 1'b0};
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL release edge %0d: got %h required %h", e, obs_a(), exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [24:0] exp;
        logic        pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            bus_a.in_sync = {5'b0, pat[k], 2'b0};
            step();
            checks++;
            if (obs_a() !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
                errors++;
                $display("FAIL bounce step %0d: got %h required %h", k, obs_a(),
                         {8'h00, 8'h00, 8'h00, 1'b0});
            end
        end
        bus_a.in_sync = 8'h04;
        for (int e = 1; e <= 4; e++) begin
            step();
            exp = (e < 4) ? {8'h00, 8'h00, 8'h00, 1'b0} : {8'h04, 8'h04, 8'h00, 1'b1};
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL bounce_hold edge %0d: got %h required %h", e, obs_a(), exp);
            end
        end
    endtask

    task automatic test_ce_gating();
        logic [24:0] exp;
        do_reset();
        // ce ticks at k=4,9,14; third tick commits on dut_b.
        bus_b.in_sync = 8'h20;
        for (int k = 0; k < 15; k++) begin
            bus_b.ce = (k % 5 == 4);
            step();
            exp = (k < 14) ? {8'h00, 8'h00, 8'h00, 1'b0} : {8'h20, 8'h20, 8'h00, 1'b1};
            checks++;
            if (obs_b() !== exp) begin
                errors++;
                $display("FAIL ce_rise k=%0d: got %h required %h", k, obs_b(), exp);
            end
        end
        bus_b.in_sync = 8'h00;
        for (int k = 0; k < 10; k++) begin
            bus_b.ce = (k % 5 == 4);
            step();
        end
        // Count is 2 of 3 here; a ce=0 dropout must still clear it.
        bus_b.ce      = 1'b0;
        bus_b.in_sync = 8'h20;
        step();
        bus_b.in_sync = 8'h00;
        for (int k = 0; k < 15; k++) begin
            bus_b.ce = (k % 5 == 4);
            step();
            exp = (k < 14) ? {8'h20, 8'h00, 8'h00, 1'b0} : {8'h00, 8'h00, 8'h20, 1'b1};
            checks++;
            if (obs_b() !== exp) begin
                errors++;
                $display("FAIL ce_dropout k=%0d: got %h required %h", k, obs_b(), exp);
            end
        end
        bus_b.ce = 1'b1;
    endtask

    task automatic test_simultaneous();
        logic [24:0] exp;
        do_reset();
        bus_a.in_sync = 8'h40;
        for (int e = 0; e < 4; e++) step();
        checks++;
        if (bus_a.level !== 8'h40) begin
            errors++;
            $display("FAIL sim_setup: got %h required %h", bus_a.level, 8'h40);
        end
        bus_a.in_sync = 8'h02;
        step();
        bus_a.in_sync = 8'h12;
        for (int e = 2; e <= 6; e++) begin
            step();
            if (e < 4)       exp = {8'h40, 8'h00, 8'h00, 1'b0};
            else if (e == 4) exp = {8'h02, 8'h02, 8'h40, 1'b1};
            else if (e == 5) exp = {8'h12, 8'h10, 8'h00, 1'b1};
            else             exp = {8'h12, 8'h00, 8'h00, 1'b0};
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL simultaneous edge %0d: got %h required %h", e, obs_a(), exp);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [24:0] exp;
        do_reset();
        bus_a.in_sync = 8'h01;
        for (int e = 0; e < 4; e++) step();
        checks++;
        if (obs_a() !== {8'h01, 8'h01, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL mid_pre_pulse: got %h required %h", obs_a(), {8'h01, 8'h01, 8'h00, 1'b1});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs_a() !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_pulse: got %h required %h", obs_a(),
                     {8'h00, 8'h00, 8'h00, 1'b0});
        end
        bus_a.in_sync = 8'h08;
        step();
        reset = 1'b0;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs_a() !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_mid: got %h required %h", obs_a(), {8'h00, 8'h00, 8'h00, 1'b0});
        end
        step();
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            exp = (e < 4) ? {8'h00, 8'h00, 8'h00, 1'b0} : {8'h08, 8'h08, 8'h00, 1'b1};
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL post_reset edge %0d: got %h required %h", e, obs_a(), exp);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus_a.ce      = 1'b1;
        bus_a.in_sync = 8'h00;
        bus_b.ce      = 1'b1;
        bus_b.in_sync = 8'h00;
        test_reset();
        test_clean_press();
        test_bounce();
        test_ce_gating();
        test_simultaneous();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Multi-channel debouncer and edge detector, one clock domain.
- Sits directly downstream of the two-flop input synchroniser on each button or joystick line.
- Takes inputs already synchronised to clk and filters contact bounce.
- Produces a stable level per channel, plus one-cycle rise/fall pulses for controller-logic and OSD consumers.

Parameters:
- WIDTH, 8: number of independent input channels.
- CNT_BITS, 16: width of each per-channel stability counter.
- STABLE_CYCLES, 50000: consecutive ce ticks of disagreement required before level changes. Legal range 1..2^CNT_BITS-1; 0 behaves as 1.
- INIT, {WIDTH{1'b0}}: reset value of level.

Ports:
- clk, input, 1: system clock; all state on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- ce, input, 1: sample-tick enable. Counters advance only when ce=1. Tie high to count raw clk cycles.
- in_sync, input, WIDTH: inputs already synchronised to clk.
- level, output, WIDTH: debounced level per channel.
- rise, output, WIDTH: one-clk pulse when level goes 0->1.
- fall, output, WIDTH: one-clk pulse when level goes 1->0.
- changed, output, 1: registered OR of rise|fall; one-clk pulse.

Behaviour:
- Reset (async assert, any time, including mid-count): level=INIT, all counters=0, rise=fall=0, changed=0. Outputs take these values immediately on assertion and hold them while reset=1.
- All outputs are registered; no combinational path from in_sync to any output.
- Per channel i, each clk edge with reset=0:
  - If in_sync[i]==level[i]: cnt[i]<=0, on every clk regardless of ce. The disagreement run is broken.
  - Else if ce=0: cnt[i] holds.
  - Else if cnt[i]==STABLE_CYCLES-1: level[i]<=in_sync[i]; cnt[i]<=0; rise[i]<=in_sync[i]; fall[i]<=~in_sync[i].
  - Else: cnt[i]<=cnt[i]+1.
- rise[i] and fall[i] are 0 on every edge not covered by the commit case above. They are never both 1.
- changed <= |(next rise | next fall). It is asserted in the same cycle as the corresponding rise/fall.
- Latency: let in_sync[i] change, and stay changed, before the edge at which the first qualifying ce=1 is sampled. Level then updates at the edge where the STABLE_CYCLES-th consecutive qualifying ce is sampled. With ce tied high this is STABLE_CYCLES clk edges after the input change.
- Glitch rejection: any return of in_sync[i] to level[i] before commit clears cnt[i]. Level does not change and no pulse is produced. The count restarts from 0 on the next disagreement.
- Counter never wraps: the maximum value held is STABLE_CYCLES-1, after which it commits and clears.
- Channels are fully independent. Simultaneous commits on several channels in one cycle are allowed, and each asserts its own rise/fall bit.
- Input toggling exactly in the commit cycle: commit uses in_sync sampled at that edge. The counter then starts fresh against the new level.
- reset deassertion: counting may begin on the first edge after deassertion. No pulse is generated for INIT vs in_sync mismatch until STABLE_CYCLES qualifying ce ticks have elapsed.

Test Plan:
- Reset value: WIDTH=8, INIT=8'h00, STABLE_CYCLES=4, ce=1. Assert reset with in_sync=8'hFF, then release. level stays 8'h00 for edges 1-3, becomes 8'hFF at edge 4 with rise=8'hFF and changed=1 for exactly one cycle.
- Clean press: STABLE_CYCLES=4, ce=1, in_sync[0] 0->1 held. level[0]=1 exactly 4 edges later; rise[0]=1 for one clk; fall=0. Release 1->0 held: fall[0] pulses after 4 edges.
- Bounce rejection: in_sync[2] pattern 1,1,1,0,1,1,1,0 (period 4, mismatch run of 3 < 4). level[2] stays 0; no rise, fall or changed. Then hold 1: commit after 4 further edges.
- ce gating: STABLE_CYCLES=3, ce high 1 in 5 clks, in_sync[5] 0->1 held. Commit at the 3rd ce edge (about 11-15 clks). While ce=0 the counter holds. A mismatch dropout with ce=0 still clears the count.
- Simultaneous and independent channels: channel 1 rises and channel 6 falls in the same edge. Expect rise=8'h02, fall=8'h40, changed=1. Other channels are unaffected during mid-count activity.
- Reset mid-count: cnt[3]=2 of 4, assert reset asynchronously between edges. level and pulses clear immediately. After release, a full 4-tick run is required before commit.
